// File: rtl/gpio_pad_ctrl.sv
// GPIO bank controller: registered pad drive/enable/pull, synchronized and
// debounced pad inputs, and rise/fall interrupt pending bits behind a small register port.
module gpio_pad_ctrl #(
  parameter int NUM_PINS = 8,
  parameter int DEB_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_we_i,
  input  logic [2:0]          cfg_addr_i,
  input  logic [NUM_PINS-1:0] cfg_wdata_i,
  output logic [NUM_PINS-1:0] cfg_rdata_o,
  output logic [NUM_PINS-1:0] pad_i_o,
  output logic [NUM_PINS-1:0] pad_oen_o,
  output logic [NUM_PINS-1:0] pad_ren_o,
  input  logic [NUM_PINS-1:0] pad_c_i,
  output logic                irq_o
);

  localparam logic [2:0] ADDR_DIR  = 3'd0;
  localparam logic [2:0] ADDR_OUT  = 3'd1;
  localparam logic [2:0] ADDR_IN   = 3'd2;
  localparam logic [2:0] ADDR_REN  = 3'd3;
  localparam logic [2:0] ADDR_IER  = 3'd4;
  localparam logic [2:0] ADDR_IEF  = 3'd5;
  localparam logic [2:0] ADDR_PEND = 3'd6;
  localparam logic [2:0] ADDR_DEB  = 3'd7;

  logic [NUM_PINS-1:0] dir_q;
  logic [NUM_PINS-1:0] out_q;
  logic [NUM_PINS-1:0] ren_q;
  logic [NUM_PINS-1:0] ier_q;
  logic [NUM_PINS-1:0] ief_q;
  logic [NUM_PINS-1:0] pend_q;
  logic [DEB_W-1:0]    deb_q;
  logic                irq_q;

  logic [NUM_PINS-1:0] sync_p0;
  logic [NUM_PINS-1:0] sync_p1;
  logic [NUM_PINS-1:0] st_q;
  logic [NUM_PINS-1:0] st_d;
  logic [NUM_PINS-1:0][DEB_W-1:0] cnt_q;
  logic [NUM_PINS-1:0][DEB_W-1:0] cnt_d;

  logic [DEB_W-1:0]    last_cnt;
  logic [NUM_PINS-1:0] rise;
  logic [NUM_PINS-1:0] fall;
  logic [NUM_PINS-1:0] pend_clr;
  logic [NUM_PINS-1:0] pend_d;
  logic                wr_dir;
  logic                wr_out;
  logic                wr_ren;
  logic                wr_ier;
  logic                wr_ief;
  logic                wr_pend;
  logic                wr_deb;

  // A threshold of zero behaves like one: a change is accepted after a single cycle.
  function automatic logic [DEB_W-1:0] final_count(input logic [DEB_W-1:0] deb);
    if (deb == '0) begin
      return '0;
    end
    return deb - DEB_W'(1);
  endfunction

  always_comb begin
    wr_dir  = cfg_we_i && (cfg_addr_i == ADDR_DIR);
    wr_out  = cfg_we_i && (cfg_addr_i == ADDR_OUT);
    wr_ren  = cfg_we_i && (cfg_addr_i == ADDR_REN);
    wr_ier  = cfg_we_i && (cfg_addr_i == ADDR_IER);
    wr_ief  = cfg_we_i && (cfg_addr_i == ADDR_IEF);
    wr_pend = cfg_we_i && (cfg_addr_i == ADDR_PEND);
    wr_deb  = cfg_we_i && (cfg_addr_i == ADDR_DEB);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dir_q <= '0;
      out_q <= '0;
      ren_q <= '0;
      ier_q <= '0;
      ief_q <= '0;
      deb_q <= '0;
    end else begin
      if (wr_dir) dir_q <= cfg_wdata_i;
      if (wr_out) out_q <= cfg_wdata_i;
      if (wr_ren) ren_q <= cfg_wdata_i;
      if (wr_ier) ier_q <= cfg_wdata_i;
      if (wr_ief) ief_q <= cfg_wdata_i;
      if (wr_deb) deb_q <= cfg_wdata_i[DEB_W-1:0];
    end
  end

  // Stage p0/p1: two-flop synchronizer for the asynchronous pad inputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= pad_c_i;
      sync_p1 <= sync_p0;
    end
  end

  // The >= compare lets a shrunk threshold take effect on a count already past it.
  always_comb begin
    last_cnt = final_count(deb_q);
    st_d     = st_q;
    cnt_d    = '0;
    for (int n = 0; n < NUM_PINS; n++) begin
      if (sync_p1[n] != st_q[n]) begin
        if (cnt_q[n] >= last_cnt) begin
          st_d[n] = sync_p1[n];
        end else begin
          cnt_d[n] = cnt_q[n] + DEB_W'(1);
        end
      end
    end
  end

  // Stage p2: debounced stable value and per-pin run counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // A new edge outranks a same-cycle write-one-to-clear on the same bit.
  always_comb begin
    rise     = st_d & ~st_q & ier_q;
    fall     = ~st_d & st_q & ief_q;
    pend_clr = wr_pend ? cfg_wdata_i : '0;
    pend_d   = (pend_q & ~pend_clr) | rise | fall;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= |pend_q;
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      ADDR_DIR:  cfg_rdata_o = dir_q;
      ADDR_OUT:  cfg_rdata_o = out_q;
      ADDR_IN:   cfg_rdata_o = st_q;
      ADDR_REN:  cfg_rdata_o = ren_q;
      ADDR_IER:  cfg_rdata_o = ier_q;
      ADDR_IEF:  cfg_rdata_o = ief_q;
      ADDR_PEND: cfg_rdata_o = pend_q;
      ADDR_DEB:  cfg_rdata_o = NUM_PINS'(deb_q);
      default:   cfg_rdata_o = '0;
    endcase
  end

  assign pad_oen_o = dir_q;
  assign pad_i_o   = out_q;
  assign pad_ren_o = ren_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: fixed vector table, hand-written debounce/interrupt
// sequences, then random traffic against a cycle-level reference model.
module tb_gpio_pad_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] pad_out;
  logic [7:0] pad_oen;
  logic [7:0] pad_ren;
  logic [7:0] pad_in;
  logic       irq;

  int n_chk  = 0;
  int n_fail = 0;

  gpio_pad_ctrl #(.NUM_PINS(8), .DEB_W(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_we_i   (we),
    .cfg_addr_i (addr),
    .cfg_wdata_i(wdata),
    .cfg_rdata_o(rdata),
    .pad_i_o    (pad_out),
    .pad_oen_o  (pad_oen),
    .pad_ren_o  (pad_ren),
    .pad_c_i    (pad_in),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  // Reference model: registers as plain bytes, pad history as a queue of
  // edge samples, and per-pin counts of consecutive cycles that disagree.
  bit [7:0] m_dir, m_out, m_ren, m_ier, m_ief, m_pend, m_deb, m_st;
  bit       m_irq;
  int       m_run [8];
  bit [7:0] seen [$];

  task automatic model_edge(input bit r, input bit w, input bit [2:0] a,
                            input bit [7:0] d, input bit [7:0] p);
    bit [7:0] s, rises, falls, clr;
    int thr;
    if (r) begin
      {m_dir, m_out, m_ren, m_ier, m_ief, m_pend, m_deb, m_st} = '0;
      m_irq = 1'b0;
      for (int n = 0; n < 8; n++) m_run[n] = 0;
      seen.delete();
      return;
    end
    s     = (seen.size() >= 2) ? seen[seen.size()-2] : 8'h00;
    thr   = (m_deb == 0) ? 1 : int'(m_deb);
    rises = '0;
    falls = '0;
    for (int n = 0; n < 8; n++) begin
      if (s[n] != m_st[n]) begin
        m_run[n]++;
        if (m_run[n] >= thr) begin
          if (s[n]) rises[n] = 1'b1;
          else      falls[n] = 1'b1;
          m_st[n]  = s[n];
          m_run[n] = 0;
        end
      end else begin
        m_run[n] = 0;
      end
    end
    clr    = (w && a == 3'd6) ? d : 8'h00;
    m_irq  = (m_pend != 0);
    m_pend = (m_pend & ~clr) | (rises & m_ier) | (falls & m_ief);
    if (w) begin
      case (a)
        3'd0: m_dir = d;
        3'd1: m_out = d;
        3'd3: m_ren = d;
        3'd4: m_ier = d;
        3'd5: m_ief = d;
        3'd7: m_deb = d;
        default: ;
      endcase
    end
    seen.push_back(p);
    if (seen.size() > 2) void'(seen.pop_front());
  endtask

  function automatic bit [7:0] model_rd(input bit [2:0] a);
    case (a)
      3'd0: return m_dir;
      3'd1: return m_out;
      3'd2: return m_st;
      3'd3: return m_ren;
      3'd4: return m_ier;
      3'd5: return m_ief;
      3'd6: return m_pend;
      default: return m_deb;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit r, input bit w, input bit [2:0] a,
                      input bit [7:0] d, input bit [7:0] p);
    rst = r; we = w; addr = a; wdata = d; pad_in = p;
    @(posedge clk);
    model_edge(r, w, a, d, p);
    @(negedge clk);
  endtask

  typedef struct {
    bit       r;
    bit       w;
    bit [2:0] a;
    bit [7:0] d;
    bit [7:0] p;
    bit [7:0] e_oen;
    bit [7:0] e_out;
    bit [7:0] e_ren;
    bit [7:0] e_rd;
    bit       e_irq;
  } vec_t;

  function automatic vec_t mk(bit r, bit w, bit [2:0] a, bit [7:0] d, bit [7:0] p,
                              bit [7:0] eo, bit [7:0] ed, bit [7:0] er, bit [7:0] rd, bit ei);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.d = d; v.p = p;
    v.e_oen = eo; v.e_out = ed; v.e_ren = er; v.e_rd = rd; v.e_irq = ei;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; pad_in = '0;

    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 0, 3'(i), 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 0, 3'd2, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 0, 3'd2, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 0, 3'd2, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 0));
    tbl.push_back(mk(0, 1, 3'd0, 8'hA5, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'hA5, 0));
    tbl.push_back(mk(0, 1, 3'd1, 8'h3C, 8'hFF, 8'hA5, 8'h3C, 8'h00, 8'h3C, 0));
    tbl.push_back(mk(0, 1, 3'd3, 8'h0F, 8'hFF, 8'hA5, 8'h3C, 8'h0F, 8'h0F, 0));
    tbl.push_back(mk(0, 1, 3'd2, 8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h0F, 8'hFF, 0));
    tbl.push_back(mk(0, 0, 3'd7, 8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h0F, 8'h00, 0));
    tbl.push_back(mk(0, 0, 3'd0, 8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h0F, 8'hA5, 0));

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].p);
      chk($sformatf("vec%0d_oen", i),   pad_oen, tbl[i].e_oen);
      chk($sformatf("vec%0d_out", i),   pad_out, tbl[i].e_out);
      chk($sformatf("vec%0d_ren", i),   pad_ren, tbl[i].e_ren);
      chk($sformatf("vec%0d_rdata", i), rdata,   tbl[i].e_rd);
      chk($sformatf("vec%0d_irq", i),   irq,     tbl[i].e_irq);
    end

    // Debounce with DEB=4: bring pin0 low, filter a 3-cycle glitch, then a real rise.
    step(0, 1, 3'd7, 8'h04, 8'hFE);
    step(0, 1, 3'd4, 8'h01, 8'hFE);
    repeat (6) step(0, 0, 3'd6, 8'h00, 8'hFE);
    chk("deb_pend_idle", rdata, 8'h00);
    step(0, 0, 3'd2, 8'h00, 8'hFE);
    chk("deb_in_low", rdata, 8'hFE);
    repeat (3) begin
      step(0, 0, 3'd2, 8'h00, 8'hFF);
      chk("glitch_in0", rdata[0], 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 3'd2, 8'h00, 8'hFE);
      chk("glitch_in0_after", rdata[0], 1'b0);
    end
    step(0, 0, 3'd6, 8'h00, 8'hFE);
    chk("glitch_pend", rdata, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      step(0, 0, 3'd6, 8'h00, 8'hFF);
      chk($sformatf("rise_pend_k%0d", k), rdata, (k >= 6) ? 8'h01 : 8'h00);
      chk($sformatf("rise_irq_k%0d", k), irq, (k >= 7));
    end
    step(0, 0, 3'd2, 8'h00, 8'hFF);
    chk("rise_in", rdata, 8'hFF);

    // Fall on pin7 with IEF, then write-one-to-clear.
    step(0, 1, 3'd5, 8'h80, 8'hFF);
    step(0, 1, 3'd6, 8'h01, 8'hFF);
    chk("clr0_pend", rdata, 8'h00);
    chk("clr0_irq_lag", irq, 1'b1);
    step(0, 0, 3'd6, 8'h00, 8'hFF);
    chk("clr0_irq", irq, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step(0, 0, 3'd6, 8'h00, 8'h7F);
      chk($sformatf("fall_pend_k%0d", k), rdata, (k >= 6) ? 8'h80 : 8'h00);
      chk($sformatf("fall_irq_k%0d", k), irq, (k >= 7));
    end
    step(0, 1, 3'd6, 8'h80, 8'h7F);
    chk("w1c_pend", rdata, 8'h00);
    chk("w1c_irq_lag", irq, 1'b1);
    step(0, 0, 3'd6, 8'h00, 8'h7F);
    chk("w1c_irq", irq, 1'b0);

    // Rise on pin2 lands on the same edge as a clear of bit 2.
    step(0, 1, 3'd4, 8'h04, 8'h7F);
    repeat (8) step(0, 0, 3'd6, 8'h00, 8'h7B);
    chk("coll_pre_pend", rdata, 8'h00);
    for (int k = 1; k <= 5; k++) step(0, 0, 3'd6, 8'h00, 8'h7F);
    step(0, 1, 3'd6, 8'h04, 8'h7F);
    chk("coll_pend", rdata, 8'h04);
    step(0, 0, 3'd6, 8'h00, 8'h7F);
    chk("coll_irq1", irq, 1'b1);
    step(0, 0, 3'd6, 8'h00, 8'h7F);
    chk("coll_irq2", irq, 1'b1);

    // Threshold shrunk from 200 to 10 while pin1 is mid-count.
    repeat (8) step(0, 0, 3'd6, 8'h00, 8'h7D);
    step(0, 1, 3'd7, 8'hC8, 8'h7D);
    step(0, 1, 3'd4, 8'h02, 8'h7D);
    step(0, 1, 3'd6, 8'hFF, 8'h7D);
    chk("shrink_pre_pend", rdata, 8'h00);
    for (int k = 1; k <= 50; k++) step(0, 0, 3'd6, 8'h00, 8'h7F);
    chk("shrink_hold_pend", rdata, 8'h00);
    step(0, 1, 3'd7, 8'h0A, 8'h7F);
    step(0, 0, 3'd6, 8'h00, 8'h7F);
    chk("shrink_pend", rdata, 8'h02);
    step(0, 0, 3'd6, 8'h00, 8'h7F);
    chk("shrink_irq", irq, 1'b1);

    // Random traffic against the model, including occasional mid-debounce resets.
    begin
      bit [7:0] p;
      p = 8'h7F;
      for (int i = 0; i < 1500; i++) begin
        bit       r, w;
        bit [2:0] a;
        bit [7:0] d;
        r = ($urandom_range(0, 149) == 0);
        w = ($urandom_range(0, 2) == 0);
        a = 3'($urandom_range(0, 7));
        d = 8'($urandom);
        if (a == 3'd7) d = 8'($urandom_range(0, 6));
        if ($urandom_range(0, 3) == 0) p = p ^ (8'h01 << $urandom_range(0, 7));
        step(r, w, a, d, p);
        chk("rnd_oen",   pad_oen, m_dir);
        chk("rnd_out",   pad_out, m_out);
        chk("rnd_ren",   pad_ren, m_ren);
        chk("rnd_rdata", rdata,   model_rd(a));
        chk("rnd_irq",   irq,     m_irq);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
